vram_cpu_arb: RTL and testbench
===============================

# vram_cpu_arb

Sequencer for CPU accesses to LSPC video RAM. It accepts the register writes to 3C0000 (address), 3C0002 (data) and 3C0004 (modulo). It queues VRAM writes in a small FIFO and issues them only in the CPU access slots granted by the slow-cycle (zone 0) and fast-cycle (zone 1) VRAM sequencers. It also keeps the read buffer at 3C0000/3C0002 refreshed with a prefetch read at the current pointer.

## Interface
Parameters:
- WFIFO_DEPTH, 2, number of queued write entries; power of two, ≥2.

Ports:
- CLK_24M  in  1  master clock; all state updates on rising edge.
- nRESET  in  1  reset, asynchronous, active-low.
- CPU_WR  in  1  one-cycle register write strobe, already synchronous to CLK_24M.
- CPU_REG  in  2  register select: 00 = address, 01 = data, 10 = modulo, 11 = ignored.
- CPU_DIN  in  16  register write data.
- CPU_DOUT  out  16  read buffer, i.e. the VRAM word at the pointer.
- REG_VRAMMOD  out  16  modulo register, readable at 3C0004.
- BUSY  out  1  write FIFO full.
- OVERFLOW  out  1  sticky flag: a data write was dropped.
- SLOT_SCY  in  1  one-cycle grant for the zone-0 CPU slot.
- SLOT_FCY  in  1  one-cycle grant for the zone-1 CPU slot.
- VRAM_REQ  out  1  a request is presented.
- VRAM_ZONE  out  1  zone of the presented request.
- VRAM_ADDR  out  15  word address; zone 1 uses [10:0].
- VRAM_WE  out  1  1 = write, 0 = read.
- VRAM_WDATA  out  16  write data.
- VRAM_RDATA  in  16  read data, valid the cycle after a read grant.

## Operation
- Pointer PTR = {zone, addr[14:0]}.
- Address write:
  - PTR <= CPU_DIN.
  - Sets PREFETCH.
  - Clears OVERFLOW.
  - Any in-flight read result is marked stale.
- Data write:
  - Enqueues {PTR, CPU_DIN}.
  - PTR.addr <= PTR.addr + REG_VRAMMOD[14:0], modulo 2^15. Zone bit is never changed.
  - Sets PREFETCH and marks any in-flight read stale.
  - If the FIFO is full: entry dropped, PTR unchanged, OVERFLOW set.
- Modulo write: REG_VRAMMOD <= CPU_DIN. No effect on the queue.
- Request selection, strict priority:
  1. FIFO head (write).
  2. Prefetch read at PTR, only when the FIFO is empty and PREFETCH = 1.
- A request is served only by the grant of its own zone: SLOT_SCY for zone 0, SLOT_FCY for zone 1. A grant for the other zone is ignored.
- State machine:
  - IDLE: VRAM_REQ = 0. Leave on FIFO non-empty or PREFETCH.
  - WAIT_SLOT: request presented, held stable until the matching grant.
  - Grant on a write: pop the FIFO; go to IDLE, or stay in WAIT_SLOT if entries remain.
  - Grant on a read: clear PREFETCH, go to CAPTURE.
  - CAPTURE (1 cycle): latch VRAM_RDATA into CPU_DOUT unless stale. If stale, set PREFETCH again. Then go to IDLE.
- Same-cycle CPU_WR and grant: the pop and the enqueue both take effect, so occupancy is unchanged. BUSY is evaluated on the pre-pop count.
- Reset, at any time: FIFO emptied, PTR = 0, REG_VRAMMOD = 0, PREFETCH = 0, state IDLE, in-flight access abandoned.

## Timing
- Reset values:
  - CPU_DOUT = 0, REG_VRAMMOD = 0, BUSY = 0, OVERFLOW = 0.
  - VRAM_REQ = 0, VRAM_ZONE = 0, VRAM_ADDR = 0, VRAM_WE = 0, VRAM_WDATA = 0.
- All outputs are registered.
- A request appears on VRAM_* one cycle after the enqueue, or after PREFETCH is set.
- Grant at cycle N → read data sampled at N+1 → CPU_DOUT valid at N+2.
- Worst case: a write issued at the next matching slot after reaching the FIFO head.
- BUSY asserts the cycle after the enqueue that fills the FIFO. It deasserts the cycle after a pop.

## Configuration
- VRAMARB_PREFETCH_EN defined: prefetch reads and CAPTURE are implemented as described above.
- VRAMARB_PREFETCH_EN undefined:
  - PREFETCH logic removed; only writes are issued, so VRAM_WE = 1 whenever VRAM_REQ = 1.
  - CPU_DOUT is held at 0.

## Test plan
- Prefetch: reset; write address 0x7000; VRAM_RDATA = 0xBEEF; one SLOT_SCY → zone 0 read at 0x7000; CPU_DOUT = 0xBEEF two cycles after the grant.
- Auto-increment: modulo 0x0001, address 0x8010, data 0x1234, data 0x5678 → zone 1 writes at 0x0010 then 0x0011, served only on SLOT_FCY; prefetch read at 0x0012 follows.
- Modulo wrap: modulo 0x0020, address 0x7FF0, one data write → next PTR addr 0x0010, zone bit still 0.
- Full FIFO, no grants: three data writes → BUSY = 1 after the second; third dropped with OVERFLOW = 1; PTR advanced only twice. A following address write clears OVERFLOW.
- Stale read: address 0x0100, grant; address 0x0200 written during CAPTURE → CPU_DOUT not updated; new read at 0x0200 issued on the next SLOT_SCY.
- Reset mid-operation: nRESET low while in WAIT_SLOT with 2 queued entries → VRAM_REQ = 0 and BUSY = 0 immediately; no access after release until a new register write.

Source files
------------

// File: rtl/vram_cpu_arb.sv
// Sequences CPU register writes into LSPC VRAM accesses, issued only in granted zone slots.
// Optional macro VRAMARB_PREFETCH_EN enables the read-buffer prefetch at the pointer.
module vram_cpu_arb #(
  parameter int WFIFO_DEPTH = 2
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        CPU_WR,
  input  logic [1:0]  CPU_REG,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic [15:0] REG_VRAMMOD,
  output logic        BUSY,
  output logic        OVERFLOW,
  input  logic        SLOT_SCY,
  input  logic        SLOT_FCY,
  output logic        VRAM_REQ,
  output logic        VRAM_ZONE,
  output logic [14:0] VRAM_ADDR,
  output logic        VRAM_WE,
  output logic [15:0] VRAM_WDATA,
  input  logic [15:0] VRAM_RDATA
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WFIFO_DEPTH);

`ifdef VRAMARB_PREFETCH_EN
  localparam logic PF_EN = 1'b1;
`else
  localparam logic PF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_CAPTURE
  } state_t;

  state_t        state;
  logic [15:0]   ptr;
  logic [31:0]   fifo_mem [WFIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          prefetch;
  logic          stale;

  logic          addr_wr, data_wr, mod_wr;
  logic          full, enq, cpu_touch;
  logic          slot_hit, pop, rd_grant;
  logic [31:0]   head;
  logic [31:0]   next_head;

  assign addr_wr   = CPU_WR && (CPU_REG == 2'b00);
  assign data_wr   = CPU_WR && (CPU_REG == 2'b01);
  assign mod_wr    = CPU_WR && (CPU_REG == 2'b10);
  // Full is judged on the pre-pop count, so a write arriving while full is dropped
  // even if a pop happens on the same edge.
  assign full      = (count == DEPTH_C);
  assign enq       = data_wr && !full;
  assign cpu_touch = addr_wr || enq;

  // A presented request is only ever served by the grant of its own zone.
  assign slot_hit  = VRAM_ZONE ? SLOT_FCY : SLOT_SCY;
  assign pop       = (state == ST_WAIT_SLOT) && VRAM_WE && slot_hit;
  assign rd_grant  = (state == ST_WAIT_SLOT) && !VRAM_WE && slot_hit;

  assign count_nxt = count + CW'(enq) - CW'(pop);
  assign rd_next   = rd_ptr + AW'(1);
  assign head      = fifo_mem[rd_ptr];

  // After a pop the new head may be the entry being enqueued on this same edge.
  always_comb begin
    next_head = fifo_mem[rd_next];
    if (count == CW'(1) && enq) next_head = {ptr, CPU_DIN};
  end

  always_ff @(posedge CLK_24M) begin
    if (enq) fifo_mem[wr_ptr] <= {ptr, CPU_DIN};
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state       <= ST_IDLE;
      ptr         <= 16'h0000;
      REG_VRAMMOD <= 16'h0000;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      prefetch    <= 1'b0;
      stale       <= 1'b0;
      BUSY        <= 1'b0;
      OVERFLOW    <= 1'b0;
      CPU_DOUT    <= 16'h0000;
      VRAM_REQ    <= 1'b0;
      VRAM_ZONE   <= 1'b0;
      VRAM_ADDR   <= 15'h0000;
      VRAM_WE     <= 1'b0;
      VRAM_WDATA  <= 16'h0000;
    end else begin
      if (mod_wr) REG_VRAMMOD <= CPU_DIN;

      if (addr_wr) begin
        ptr      <= CPU_DIN;
        OVERFLOW <= 1'b0;
      end else if (data_wr) begin
        if (full) OVERFLOW <= 1'b1;
        else      ptr <= {ptr[15], ptr[14:0] + REG_VRAMMOD[14:0]};
      end

      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_next;
      count <= count_nxt;
      BUSY  <= (count_nxt == DEPTH_C);

      if (cpu_touch || (state == ST_CAPTURE && stale)) prefetch <= PF_EN;
      else if (rd_grant)                               prefetch <= 1'b0;

      stale <= stale || cpu_touch;

      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            VRAM_REQ                <= 1'b1;
            {VRAM_ZONE, VRAM_ADDR}  <= head[31:16];
            VRAM_WE                 <= 1'b1;
            VRAM_WDATA              <= head[15:0];
            state                   <= ST_WAIT_SLOT;
          end else if (prefetch && !cpu_touch) begin
            // A read launched while the pointer is changing would be stale at once.
            VRAM_REQ               <= 1'b1;
            {VRAM_ZONE, VRAM_ADDR} <= ptr;
            VRAM_WE                <= 1'b0;
            VRAM_WDATA             <= 16'h0000;
            stale                  <= 1'b0;
            state                  <= ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          if (pop) begin
            if (count_nxt != '0) begin
              {VRAM_ZONE, VRAM_ADDR} <= next_head[31:16];
              VRAM_WDATA             <= next_head[15:0];
            end else begin
              VRAM_REQ <= 1'b0;
              state    <= ST_IDLE;
            end
          end else if (rd_grant) begin
            VRAM_REQ <= 1'b0;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!(stale || cpu_touch)) CPU_DOUT <= VRAM_RDATA;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_cpu_arb.sv
// Directed bench for vram_cpu_arb: cycle table plus hand-written multi-cycle sequences.
// Expectations follow VRAMARB_PREFETCH_EN when the bench is built with it.
module tb_vram_cpu_arb;

`ifdef VRAMARB_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  logic        CLK_24M;
  logic        nRESET;
  logic        CPU_WR;
  logic [1:0]  CPU_REG;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic [15:0] REG_VRAMMOD;
  logic        BUSY;
  logic        OVERFLOW;
  logic        SLOT_SCY;
  logic        SLOT_FCY;
  logic        VRAM_REQ;
  logic        VRAM_ZONE;
  logic [14:0] VRAM_ADDR;
  logic        VRAM_WE;
  logic [15:0] VRAM_WDATA;
  logic [15:0] VRAM_RDATA;

  vram_cpu_arb #(.WFIFO_DEPTH(2)) dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET),
    .CPU_WR(CPU_WR), .CPU_REG(CPU_REG), .CPU_DIN(CPU_DIN),
    .CPU_DOUT(CPU_DOUT), .REG_VRAMMOD(REG_VRAMMOD),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW),
    .SLOT_SCY(SLOT_SCY), .SLOT_FCY(SLOT_FCY),
    .VRAM_REQ(VRAM_REQ), .VRAM_ZONE(VRAM_ZONE), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_WE(VRAM_WE), .VRAM_WDATA(VRAM_WDATA), .VRAM_RDATA(VRAM_RDATA)
  );

  // clock / reset
  initial CLK_24M = 1'b0;
  always #5 CLK_24M = ~CLK_24M;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  rsel;
    logic [15:0] din;
    logic        scy;
    logic        fcy;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_zone;
    logic [14:0] e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    logic        e_busy;
    logic        e_ovf;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bus fields only matter while a request is presented.
  function automatic logic [63:0] bus_obs();
    return {30'h0, VRAM_REQ,
            (VRAM_REQ ? {VRAM_ZONE, VRAM_ADDR, VRAM_WE, VRAM_WDATA} : 33'h0)};
  endfunction

  function automatic logic [63:0] bus_exp(input logic req, input logic zone,
                                          input logic [14:0] addr, input logic we,
                                          input logic [15:0] wdata);
    return {30'h0, req, (req ? {zone, addr, we, wdata} : 33'h0)};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] rsel, input logic [15:0] din,
                              input logic scy, input logic fcy, input logic [15:0] rdata,
                              input logic req, input logic zone, input logic [14:0] addr,
                              input logic we, input logic [15:0] wdata, input logic busy,
                              input logic ovf, input logic [15:0] dout);
    vec_t v;
    v.wr = wr; v.rsel = rsel; v.din = din; v.scy = scy; v.fcy = fcy; v.rdata = rdata;
    v.e_req = req; v.e_zone = zone; v.e_addr = addr; v.e_we = we; v.e_wdata = wdata;
    v.e_busy = busy; v.e_ovf = ovf; v.e_dout = dout;
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge CLK_24M);
    #1;
  endtask

  task automatic idle_inputs();
    CPU_WR = 1'b0; CPU_REG = 2'b00; CPU_DIN = 16'h0;
    SLOT_SCY = 1'b0; SLOT_FCY = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] r, input logic [15:0] d);
    CPU_WR = 1'b1; CPU_REG = r; CPU_DIN = d;
    step();
    CPU_WR = 1'b0; CPU_REG = 2'b00; CPU_DIN = 16'h0;
  endtask

  task automatic grant(input logic fcy);
    if (fcy) SLOT_FCY = 1'b1;
    else     SLOT_SCY = 1'b1;
    step();
    SLOT_SCY = 1'b0; SLOT_FCY = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    VRAM_RDATA = 16'h0;
    nRESET = 1'b0;
    #3;
    chk({tag, "_rst_bus"}, bus_obs(), bus_exp(1'b0, 1'b0, 15'h0, 1'b0, 16'h0));
    chk({tag, "_rst_busy"}, 64'(BUSY), 64'(0));
    @(negedge CLK_24M);
    nRESET = 1'b1;
    step();
  endtask

  logic [15:0] dc, d1, d2;

  initial begin
    idle_inputs();
    VRAM_RDATA = 16'h0;
    nRESET = 1'b0;
    #12;
    // Every output is zero in reset, including the raw bus fields.
    chk("rst_dout", 64'(CPU_DOUT), 64'(0));
    chk("rst_mod", 64'(REG_VRAMMOD), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_ovf", 64'(OVERFLOW), 64'(0));
    chk("rst_req", 64'(VRAM_REQ), 64'(0));
    chk("rst_zone", 64'(VRAM_ZONE), 64'(0));
    chk("rst_addr", 64'(VRAM_ADDR), 64'(0));
    chk("rst_we", 64'(VRAM_WE), 64'(0));
    chk("rst_wdata", 64'(VRAM_WDATA), 64'(0));
    @(negedge CLK_24M);
    nRESET = 1'b1;
    step();

    // Auto-increment in zone 1, then modulo wrap in zone 0.
    dc = PF ? 16'hCAFE : 16'h0;
    d1 = PF ? 16'h1111 : 16'h0;
    d2 = PF ? 16'h2222 : 16'h0;
    vecs[0]  = mk(1, 2'b10, 16'h0001, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, 16'h0);
    vecs[1]  = mk(1, 2'b00, 16'h8010, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, 16'h0);
    vecs[2]  = mk(1, 2'b01, 16'h1234, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, 16'h0);
    vecs[3]  = mk(1, 2'b01, 16'h5678, 0, 0, 16'h0,    1, 1, 15'h0010, 1, 16'h1234, 1, 0, 16'h0);
    vecs[4]  = mk(0, 2'b00, 16'h0,    1, 0, 16'h0,    1, 1, 15'h0010, 1, 16'h1234, 1, 0, 16'h0);
    vecs[5]  = mk(0, 2'b00, 16'h0,    0, 1, 16'h0,    1, 1, 15'h0011, 1, 16'h5678, 0, 0, 16'h0);
    vecs[6]  = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    1, 1, 15'h0011, 1, 16'h5678, 0, 0, 16'h0);
    vecs[7]  = mk(0, 2'b00, 16'h0,    0, 1, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, 16'h0);
    vecs[8]  = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    PF, 1, 15'h0012, 0, 16'h0,   0, 0, 16'h0);
    vecs[9]  = mk(0, 2'b00, 16'h0,    0, 1, 16'hCAFE, 0, 0, 15'h0,    0, 16'h0,    0, 0, 16'h0);
    vecs[10] = mk(0, 2'b00, 16'h0,    0, 0, 16'hCAFE, 0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[11] = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[12] = mk(1, 2'b10, 16'h0020, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[13] = mk(1, 2'b00, 16'h7FF0, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[14] = mk(1, 2'b01, 16'hAAAA, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[15] = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    1, 0, 15'h7FF0, 1, 16'hAAAA, 0, 0, dc);
    vecs[16] = mk(0, 2'b00, 16'h0,    1, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[17] = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    PF, 0, 15'h0010, 0, 16'h0,   0, 0, dc);
    vecs[18] = mk(0, 2'b00, 16'h0,    1, 0, 16'h1111, 0, 0, 15'h0,    0, 16'h0,    0, 0, dc);
    vecs[19] = mk(0, 2'b00, 16'h0,    0, 0, 16'h1111, 0, 0, 15'h0,    0, 16'h0,    0, 0, d1);
    vecs[20] = mk(1, 2'b01, 16'h5555, 0, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, d1);
    vecs[21] = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    1, 0, 15'h0010, 1, 16'h5555, 0, 0, d1);
    vecs[22] = mk(0, 2'b00, 16'h0,    1, 0, 16'h0,    0, 0, 15'h0,    0, 16'h0,    0, 0, d1);
    vecs[23] = mk(0, 2'b00, 16'h0,    0, 0, 16'h0,    PF, 0, 15'h0030, 0, 16'h0,   0, 0, d1);
    vecs[24] = mk(0, 2'b00, 16'h0,    1, 0, 16'h2222, 0, 0, 15'h0,    0, 16'h0,    0, 0, d1);
    vecs[25] = mk(0, 2'b00, 16'h0,    0, 0, 16'h2222, 0, 0, 15'h0,    0, 16'h0,    0, 0, d2);

    for (int i = 0; i < 26; i++) begin
      CPU_WR = vecs[i].wr; CPU_REG = vecs[i].rsel; CPU_DIN = vecs[i].din;
      SLOT_SCY = vecs[i].scy; SLOT_FCY = vecs[i].fcy; VRAM_RDATA = vecs[i].rdata;
      step();
      chk($sformatf("vec%0d_bus", i), bus_obs(),
          bus_exp(vecs[i].e_req, vecs[i].e_zone, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_wdata));
      chk($sformatf("vec%0d_busy", i), 64'(BUSY), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_ovf", i), 64'(OVERFLOW), 64'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_dout", i), 64'(CPU_DOUT), 64'(vecs[i].e_dout));
    end
    idle_inputs();
    chk("tbl_mod", 64'(REG_VRAMMOD), 64'(16'h0020));

    // Prefetch read after an address write.
    do_reset("pf");
    cpu_write(2'b00, 16'h7000);
    step();
    chk("pf_req", bus_obs(), bus_exp(PF, 1'b0, 15'h7000, 1'b0, 16'h0));
    VRAM_RDATA = 16'hBEEF;
    grant(1'b0);
    chk("pf_dout_early", 64'(CPU_DOUT), 64'(0));
    step();
    chk("pf_dout", 64'(CPU_DOUT), 64'(PF ? 16'hBEEF : 16'h0));
    VRAM_RDATA = 16'h0;

    // Full FIFO with no grants, then drain.
    do_reset("full");
    cpu_write(2'b10, 16'h0001);
    cpu_write(2'b00, 16'h0000);
    cpu_write(2'b01, 16'hA001);
    chk("full_busy1", 64'(BUSY), 64'(0));
    cpu_write(2'b01, 16'hA002);
    chk("full_busy2", 64'(BUSY), 64'(1));
    chk("full_ovf2", 64'(OVERFLOW), 64'(0));
    cpu_write(2'b01, 16'hA003);
    chk("full_ovf3", 64'(OVERFLOW), 64'(1));
    chk("full_busy3", 64'(BUSY), 64'(1));
    chk("full_head", bus_obs(), bus_exp(1'b1, 1'b0, 15'h0000, 1'b1, 16'hA001));
    grant(1'b0);
    chk("full_busy_pop", 64'(BUSY), 64'(0));
    chk("full_head2", bus_obs(), bus_exp(1'b1, 1'b0, 15'h0001, 1'b1, 16'hA002));
    grant(1'b0);
    chk("full_drained", bus_obs(), bus_exp(1'b0, 1'b0, 15'h0, 1'b0, 16'h0));
    cpu_write(2'b01, 16'h9999);
    step();
    chk("full_ptr2", bus_obs(), bus_exp(1'b1, 1'b0, 15'h0002, 1'b1, 16'h9999));
    chk("full_ovf_sticky", 64'(OVERFLOW), 64'(1));
    cpu_write(2'b00, 16'h0040);
    chk("full_ovf_clr", 64'(OVERFLOW), 64'(0));

    // Address write landing in the capture cycle discards the returned data.
    do_reset("stale");
    cpu_write(2'b00, 16'h0100);
    step();
    chk("stale_req1", bus_obs(), bus_exp(PF, 1'b0, 15'h0100, 1'b0, 16'h0));
    grant(1'b0);
    VRAM_RDATA = 16'hDEAD;
    cpu_write(2'b00, 16'h0200);
    chk("stale_dout", 64'(CPU_DOUT), 64'(0));
    VRAM_RDATA = 16'h0;
    step();
    chk("stale_req2", bus_obs(), bus_exp(PF, 1'b0, 15'h0200, 1'b0, 16'h0));
    grant(1'b1);
    chk("stale_wrong_zone", bus_obs(), bus_exp(PF, 1'b0, 15'h0200, 1'b0, 16'h0));
    VRAM_RDATA = 16'h4321;
    grant(1'b0);
    step();
    chk("stale_dout2", 64'(CPU_DOUT), 64'(PF ? 16'h4321 : 16'h0));
    VRAM_RDATA = 16'h0;

    // Reset while waiting with two queued writes.
    do_reset("mid");
    cpu_write(2'b10, 16'h0001);
    cpu_write(2'b00, 16'h0500);
    cpu_write(2'b01, 16'h0001);
    cpu_write(2'b01, 16'h0002);
    chk("mid_req", bus_obs(), bus_exp(1'b1, 1'b0, 15'h0500, 1'b1, 16'h0001));
    chk("mid_busy", 64'(BUSY), 64'(1));
    nRESET = 1'b0;
    #2;
    chk("mid_rst_req", 64'(VRAM_REQ), 64'(0));
    chk("mid_rst_busy", 64'(BUSY), 64'(0));
    chk("mid_rst_mod", 64'(REG_VRAMMOD), 64'(0));
    @(negedge CLK_24M);
    nRESET = 1'b1;
    SLOT_SCY = 1'b1; SLOT_FCY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("mid_quiet%0d", i), 64'(VRAM_REQ), 64'(0));
    end
    idle_inputs();
    cpu_write(2'b01, 16'h7777);
    step();
    chk("mid_new_wr", bus_obs(), bus_exp(1'b1, 1'b0, 15'h0000, 1'b1, 16'h7777));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
